// File: rtl/ring_buffer_bank_if.sv
// Bus bundle for ring_buffer_bank: per-channel push/pop handshakes, flush strobes,
// occupancy/status flags and the shared single-port RAM port.
// slave = the buffer bank itself, master = the requestors plus the RAM model.
interface ring_buffer_bank_if #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 128,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CHANNELS-1:0]        push_req;
    logic [CHANNELS*DATA_W-1:0] push_data;
    logic [CHANNELS-1:0]        push_done;
    logic [CHANNELS-1:0]        pop_req;
    logic [CHANNELS*DATA_W-1:0] pop_data;
    logic [CHANNELS-1:0]        pop_done;
    logic [CHANNELS-1:0]        clear;
    logic [CHANNELS*CNT_W-1:0]  count;
    logic [CHANNELS-1:0]        empty;
    logic [CHANNELS-1:0]        full;
    logic [CHANNELS-1:0]        overflow;
    logic [CHANNELS-1:0]        underflow;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic                       mem_we;
    logic                       mem_re;
    logic [DATA_W-1:0]          mem_rdata;

    modport slave (
        input  push_req, push_data, pop_req, clear, mem_rdata,
        output push_done, pop_data, pop_done, count, empty, full,
               overflow, underflow, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output push_req, push_data, pop_req, clear, mem_rdata,
        input  push_done, pop_data, pop_done, count, empty, full,
               overflow, underflow, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/ring_buffer_bank.sv
// Bank of CHANNELS ring buffers sharing one single-port synchronous RAM, round-robin arbitrated.
// Latency from request sampled in ARB: push_done +2 cycles, pop_done +3 cycles; one op in flight.
// Requestors hold req until their done pulse; overflow/underflow drop the op but still complete it.
// Ports: clk, rst (async active-low), bus (slave modport: handshakes, status, RAM port).
module ring_buffer_bank #(
    parameter int                CHANNELS  = 4,
    parameter int                DEPTH     = 128,
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst,
    ring_buffer_bank_if.slave  bus
);
    localparam int NREQ = 2 * CHANNELS;
    localparam int GW   = $clog2(NREQ);
    localparam int CHW  = (GW > 1) ? GW - 1 : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    typedef enum logic [1:0] {ARB, ACCESS, WAIT, DONE} state_t;

    state_t              r_state;
    logic [GW-1:0]       r_last_grant;
    logic [GW-1:0]       r_gnt;
    logic                r_ok;          // full/empty verdict taken in the ARB cycle
    logic [PW-1:0]       r_wptr     [CHANNELS];
    logic [PW-1:0]       r_rptr     [CHANNELS];
    logic [CW-1:0]       r_count    [CHANNELS];
    logic [DATA_W-1:0]   r_pop_data [CHANNELS];
    logic [CHANNELS-1:0] r_push_done;
    logic [CHANNELS-1:0] r_pop_done;
    logic [CHANNELS-1:0] r_ovf;
    logic [CHANNELS-1:0] r_unf;
    logic                r_mem_we;
    logic                r_mem_re;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [NREQ-1:0]     w_req;
    logic                w_found;
    logic [GW-1:0]       w_win;
    logic [CHW-1:0]      w_win_ch;
    logic                w_win_pop;
    logic                w_win_ok;
    logic [PW-1:0]       w_win_ptr;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic [CHW-1:0]      w_cur_ch;
    logic                w_cur_pop;

    // Requestor 2c = push of channel c, 2c+1 = pop of channel c. Search starts one past
    // the last grant, so any held request is reached within NREQ grants.
    always_comb begin
        w_req   = '0;
        w_found = 1'b0;
        w_win   = r_last_grant;
        for (int c = 0; c < CHANNELS; c++) begin
            w_req[2*c]   = bus.push_req[c];
            w_req[2*c+1] = bus.pop_req[c];
        end
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_found && w_req[(int'(r_last_grant) + i) % NREQ]) begin
                w_found = 1'b1;
                w_win   = GW'((int'(r_last_grant) + i) % NREQ);
            end
        end
    end

    assign w_win_ch    = CHW'(w_win >> 1);
    assign w_win_pop   = w_win[0];
    assign w_win_ok    = w_win_pop ? (r_count[w_win_ch] != '0) : (r_count[w_win_ch] != CW'(DEPTH));
    assign w_win_ptr   = w_win_pop ? r_rptr[w_win_ch] : r_wptr[w_win_ch];
    // DEPTH is a power of two and the pointer is PW bits, so the address cannot leave the region.
    assign w_win_addr  = BASE_ADDR + ADDR_W'(DEPTH * int'(w_win_ch)) + ADDR_W'(w_win_ptr);
    assign w_win_wdata = bus.push_data[int'(w_win_ch)*DATA_W +: DATA_W];
    assign w_cur_ch    = CHW'(r_gnt >> 1);
    assign w_cur_pop   = r_gnt[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ARB;
            r_last_grant <= GW'(NREQ - 1);
            r_gnt        <= '0;
            r_ok         <= 1'b0;
            r_push_done  <= '0;
            r_pop_done   <= '0;
            r_ovf        <= '0;
            r_unf        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_wptr[c]     <= '0;
                r_rptr[c]     <= '0;
                r_count[c]    <= '0;
                r_pop_data[c] <= '0;
            end
        end else begin
            r_push_done <= '0;
            r_pop_done  <= '0;
            case (r_state)
                ARB: begin
                    if (w_found) begin
                        r_gnt        <= w_win;
                        r_last_grant <= w_win;
                        r_ok         <= w_win_ok;
                        // Memory strobes are registered here so they are high exactly in ACCESS.
                        r_mem_we     <= w_win_ok && !w_win_pop;
                        r_mem_re     <= w_win_ok && w_win_pop;
                        r_mem_addr   <= w_win_ok ? w_win_addr : '0;
                        r_mem_wdata  <= (w_win_ok && !w_win_pop) ? w_win_wdata : '0;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_mem_we    <= 1'b0;
                    r_mem_re    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    if (w_cur_pop) begin
                        if (r_ok) begin
                            r_rptr[w_cur_ch]  <= r_rptr[w_cur_ch] + PW'(1);
                            r_count[w_cur_ch] <= r_count[w_cur_ch] - CW'(1);
                            r_state           <= WAIT;
                        end else begin
                            r_unf[w_cur_ch]      <= 1'b1;
                            r_pop_done[w_cur_ch] <= 1'b1;
                            r_state              <= DONE;
                        end
                    end else begin
                        if (r_ok) begin
                            r_wptr[w_cur_ch]  <= r_wptr[w_cur_ch] + PW'(1);
                            r_count[w_cur_ch] <= r_count[w_cur_ch] + CW'(1);
                        end else begin
                            r_ovf[w_cur_ch] <= 1'b1;
                        end
                        r_push_done[w_cur_ch] <= 1'b1;
                        r_state               <= DONE;
                    end
                end
                WAIT: begin
                    r_pop_data[w_cur_ch] <= bus.mem_rdata;
                    r_pop_done[w_cur_ch] <= 1'b1;
                    r_state              <= DONE;
                end
                DONE:    r_state <= ARB;
                default: r_state <= ARB;
            endcase
            // Flush overrides any pointer/count/flag update made above in the same cycle.
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.clear[c]) begin
                    r_wptr[c]  <= '0;
                    r_rptr[c]  <= '0;
                    r_count[c] <= '0;
                    r_ovf[c]   <= 1'b0;
                    r_unf[c]   <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.pop_data = '0;
        bus.count    = '0;
        bus.empty    = '0;
        bus.full     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bus.pop_data[c*DATA_W +: DATA_W] = r_pop_data[c];
            bus.count[c*CW +: CW]            = r_count[c];
            bus.empty[c]                     = (r_count[c] == '0);
            bus.full[c]                      = (r_count[c] == CW'(DEPTH));
        end
    end

    assign bus.push_done = r_push_done;
    assign bus.pop_done  = r_pop_done;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_re    = r_mem_re;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_ring_buffer_bank.sv
// Testbench for ring_buffer_bank: directed steps plus random push/pop/clear traffic,
// checked against a per-channel queue model and a behavioural single-port RAM.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_ring_buffer_bank;
    localparam int              CH    = 4;
    localparam int              DEPTH = 128;
    localparam int              DW    = 16;
    localparam int              AW    = 16;
    localparam int              CW    = 8;
    localparam logic [AW-1:0]   BASE  = 16'h0000;

    logic clk;
    logic rst;

    ring_buffer_bank_if #(.CHANNELS(CH), .DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) bus ();

    ring_buffer_bank #(
        .CHANNELS(CH), .DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared RAM: read data appears the cycle after mem_re.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Reference model: a FIFO queue, read/write index and sticky flags per channel.
    logic [DW-1:0] mq [CH][$];
    int            wp [CH];
    int            rp [CH];
    logic [CH-1:0] movf;
    logic [CH-1:0] munf;
    logic [DW-1:0] mlast [CH];

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int c);
        mq[c].delete();
        wp[c]   = 0;
        rp[c]   = 0;
        movf[c] = 1'b0;
        munf[c] = 1'b0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            model_clear(c);
            mlast[c] = '0;
        end
    endtask

    task automatic check_status(input string tag);
        logic [CH*CW-1:0] ec;
        logic [CH*DW-1:0] ep;
        logic [CH-1:0]    ee;
        logic [CH-1:0]    ef;
        for (int c = 0; c < CH; c++) begin
            ec[c*CW +: CW] = CW'(mq[c].size());
            ep[c*DW +: DW] = mlast[c];
            ee[c]          = (mq[c].size() == 0);
            ef[c]          = (mq[c].size() == DEPTH);
        end
        check({tag, "_count"}, bus.count, ec);
        check({tag, "_empty"}, bus.empty, ee);
        check({tag, "_full"}, bus.full, ef);
        check({tag, "_ovf"}, bus.overflow, movf);
        check({tag, "_unf"}, bus.underflow, munf);
        check({tag, "_popdata"}, bus.pop_data, ep);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_push_done"}, bus.push_done, 0);
        check({tag, "_pop_done"}, bus.pop_done, 0);
        check({tag, "_pop_data"}, bus.pop_data, 0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_empty"}, bus.empty, 4'hF);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_ovf"}, bus.overflow, 0);
        check({tag, "_unf"}, bus.underflow, 0);
        check({tag, "_we"}, bus.mem_we, 0);
        check({tag, "_re"}, bus.mem_re, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_wdata"}, bus.mem_wdata, 0);
    endtask

    // One isolated push or pop, started while the bank is idle.
    task automatic do_op(input int ch, input bit is_pop, input logic [DW-1:0] d, input string tag);
        bit            ok;
        bit            got;
        int            lat;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_pd;
        @(negedge clk);
        ok       = is_pop ? (mq[ch].size() != 0) : (mq[ch].size() != DEPTH);
        exp_addr = BASE + AW'(ch * DEPTH + (is_pop ? rp[ch] : wp[ch]));
        if (is_pop) begin
            bus.pop_req[ch] = 1'b1;
        end else begin
            bus.push_data[ch*DW +: DW] = d;
            bus.push_req[ch]           = 1'b1;
        end
        @(negedge clk);
        check({tag, "_we"}, bus.mem_we, !is_pop && ok);
        check({tag, "_re"}, bus.mem_re, is_pop && ok);
        if (ok) check({tag, "_addr"}, bus.mem_addr, exp_addr);
        if (ok && !is_pop) check({tag, "_wdata"}, bus.mem_wdata, d);
        lat = 1;
        got = is_pop ? bus.pop_done[ch] : bus.push_done[ch];
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            got = is_pop ? bus.pop_done[ch] : bus.push_done[ch];
        end
        check({tag, "_latency"}, lat, (is_pop && ok) ? 3 : 2);
        bus.push_req[ch] = 1'b0;
        bus.pop_req[ch]  = 1'b0;
        if (is_pop) begin
            if (ok) begin
                exp_pd    = mq[ch].pop_front();
                rp[ch]    = (rp[ch] + 1) % DEPTH;
                mlast[ch] = exp_pd;
            end else begin
                munf[ch] = 1'b1;
            end
        end else begin
            if (ok) begin
                mq[ch].push_back(d);
                wp[ch] = (wp[ch] + 1) % DEPTH;
            end else begin
                movf[ch] = 1'b1;
            end
        end
        check_status(tag);
    endtask

    task automatic do_clear(input int ch);
        @(negedge clk);
        bus.clear[ch] = 1'b1;
        @(negedge clk);
        bus.clear[ch] = 1'b0;
        model_clear(ch);
        check_status("clear");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] gd [CH];
        logic [DW-1:0] exp_pd;
        int            k;
        int            cyc;
        int            idx;
        int            r;
        int            ch;

        n_cmp = 0;
        n_err = 0;
        rst            = 1'b1;
        bus.push_req   = '0;
        bus.pop_req    = '0;
        bus.push_data  = '0;
        bus.clear      = '0;
        #2 rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // First push after reset lands at channel 0 word 0.
        do_op(0, 1'b0, 16'hA5A5, "ch0_first_push");

        // Fill and drain channel 2 through its whole region, wrapping both pointers.
        for (int i = 0; i < DEPTH; i++) do_op(2, 1'b0, DW'(i), "ch2_fill");
        for (int i = 0; i < DEPTH; i++) do_op(2, 1'b1, '0, "ch2_drain");
        do_op(2, 1'b0, 16'h5A5A, "ch2_wrap_push");
        do_op(2, 1'b1, '0, "ch2_wrap_pop");

        // Overflow on channel 1, underflow on channel 3.
        for (int i = 0; i < DEPTH; i++) do_op(1, 1'b0, DW'($urandom), "ch1_fill");
        do_op(1, 1'b0, 16'hDEAD, "ch1_overflow");
        do_op(3, 1'b1, '0, "ch3_underflow");

        // Flush of channel 0 landing in the ACCESS cycle of its own push.
        for (int i = 0; i < 4; i++) do_op(0, 1'b0, DW'(16'h0100 + i), "ch0_to5");
        @(negedge clk);
        bus.push_data[0 +: DW] = 16'hBEEF;
        bus.push_req[0]        = 1'b1;
        @(negedge clk);
        check("clr_acc_we", bus.mem_we, 1);
        check("clr_acc_addr", bus.mem_addr, BASE + AW'(wp[0]));
        bus.clear[0] = 1'b1;
        @(negedge clk);
        bus.clear[0] = 1'b0;
        check("clr_push_done", bus.push_done, 4'b0001);
        bus.push_req[0] = 1'b0;
        model_clear(0);
        check_status("clr_during_access");

        // Random single operations against the model.
        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom_range(0, 9));
            ch = int'($urandom_range(0, CH - 1));
            if (r == 0)     do_clear(ch);
            else if (r < 5) do_op(ch, 1'b1, '0, "rand_pop");
            else            do_op(ch, 1'b0, DW'($urandom), "rand_push");
        end

        // Reset while a pop is waiting for RAM data.
        do_op(0, 1'b0, 16'h1234, "pre_rst_push");
        @(negedge clk);
        bus.pop_req[0] = 1'b1;
        @(negedge clk);
        check("rst_acc_re", bus.mem_re, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_in_wait");
        repeat (2) begin
            @(negedge clk);
            check("rst_no_pop_done", bus.pop_done, 0);
        end
        bus.pop_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // All eight requestors held: grants 0..7 then 0 again.
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            gd[c]                     = DW'($urandom);
            bus.push_data[c*DW +: DW] = gd[c];
        end
        bus.push_req = '1;
        bus.pop_req  = '1;
        k   = 0;
        cyc = 0;
        while (k < 9 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (|bus.push_done || |bus.pop_done) begin
                idx = -1;
                for (int c = CH - 1; c >= 0; c--) begin
                    if (bus.push_done[c]) idx = 2 * c;
                    if (bus.pop_done[c])  idx = 2 * c + 1;
                end
                check("grant_order", idx, k % (2 * CH));
                ch = idx / 2;
                if (idx % 2 == 0) begin
                    if (mq[ch].size() < DEPTH) begin
                        mq[ch].push_back(gd[ch]);
                        wp[ch] = (wp[ch] + 1) % DEPTH;
                    end else begin
                        movf[ch] = 1'b1;
                    end
                end else begin
                    if (mq[ch].size() > 0) begin
                        exp_pd    = mq[ch].pop_front();
                        rp[ch]    = (rp[ch] + 1) % DEPTH;
                        mlast[ch] = exp_pd;
                        check("grant_pop_data", bus.pop_data[ch*DW +: DW], exp_pd);
                    end else begin
                        munf[ch] = 1'b1;
                    end
                end
                k++;
                if (k == 9) begin
                    bus.push_req = '0;
                    bus.pop_req  = '0;
                end
            end
        end
        check("grant_total", k, 9);
        bus.push_req = '0;
        bus.pop_req  = '0;
        repeat (3) @(negedge clk);
        check_status("after_grants");

        // Pop on an empty channel after the reset: only underflow[3] rises.
        do_op(3, 1'b1, '0, "post_rst_underflow");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ring_buffer_bank.md
RING_BUFFER_BANK -- requirements
Module: ring_buffer_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent ring buffers; legal range 1..8.
REQ-002 Parameter DEPTH, default 128, words per channel; power of two, 2..4096.
REQ-003 Parameter DATA_W, default 16, word width.
REQ-004 Parameter ADDR_W, default 16, memory address width; CHANNELS*DEPTH SHALL fit in ADDR_W bits.
REQ-005 Parameter BASE_ADDR, default 16'h0000, memory address of channel 0 word 0.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 push_req  in  CHANNELS  per-channel write request, held until push_done.
REQ-010 push_data  in  CHANNELS*DATA_W  write word, channel c at [c*DATA_W +: DATA_W], stable while push_req.
REQ-011 push_done  out  CHANNELS  one-cycle write completion pulse.
REQ-012 pop_req  in  CHANNELS  per-channel read request, held until pop_done.
REQ-013 pop_data  out  CHANNELS*DATA_W  read word, valid in the pop_done cycle, held until the next pop of that channel.
REQ-014 pop_done  out  CHANNELS  one-cycle read completion pulse.
REQ-015 clear  in  CHANNELS  per-channel synchronous flush strobe.
REQ-016 count  out  CHANNELS*(log2(DEPTH)+1)  per-channel occupancy.
REQ-017 empty / full  out  CHANNELS each  count==0 / count==DEPTH.
REQ-018 overflow / underflow  out  CHANNELS each  sticky error flags.
REQ-019 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_we  out  1; mem_re  out  1; mem_rdata  in  DATA_W -- shared single-port synchronous RAM, read data valid the cycle after mem_re.

Function
REQ-020 Requestor index 2c = push of channel c, 2c+1 = pop of channel c; 2*CHANNELS requestors share the memory port.
REQ-021 FSM states ARB, ACCESS, WAIT, DONE; one memory operation in flight at a time.
REQ-022 ARB: if any req high, register winner by round-robin starting at (last_grant+1) mod 2*CHANNELS, go to ACCESS; else stay in ARB.
REQ-023 last_grant updates to the winner on each grant; round-robin order SHALL guarantee every held request is served within 2*CHANNELS grants.
REQ-024 Full/empty decision for the winner SHALL use count at the ARB cycle.
REQ-025 ACCESS, push, not full: mem_we=1, mem_addr=BASE_ADDR+c*DEPTH+wptr[c], mem_wdata=push_data[c]; at edge wptr[c] increments mod DEPTH, count[c] increments; next state DONE.
REQ-026 ACCESS, pop, not empty: mem_re=1, mem_addr=BASE_ADDR+c*DEPTH+rptr[c]; at edge rptr[c] increments mod DEPTH, count[c] decrements; next state WAIT.
REQ-027 WAIT: pop_data[c] captures mem_rdata; next state DONE.
REQ-028 DONE: push_done[c] or pop_done[c] high for exactly this cycle; next state ARB.
REQ-029 Latency from req sampled in ARB: push_done 2 cycles later, pop_done 3 cycles later.
REQ-030 Push while full: no mem_we, pointers/count unchanged, overflow[c] set, ACCESS->DONE, push_done still pulses (word dropped).
REQ-031 Pop while empty: no mem_re, pop_data[c] unchanged, underflow[c] set, ACCESS->DONE, pop_done still pulses.
REQ-032 mem_we and mem_re SHALL be 0 in every state other than ACCESS, and never both 1.
REQ-033 Pointer wrap: DEPTH-1 increments to 0; channel addresses SHALL never leave the channel's region.
REQ-034 clear[c]: at next edge wptr[c], rptr[c], count[c], overflow[c], underflow[c] go to 0; other channels unaffected.
REQ-035 clear[c] during ACCESS for channel c: clear wins, the op's pointer/count update is discarded, the handshake still completes with a done pulse; read data still returned.
REQ-036 Simultaneous push and pop on one channel are serialised by the arbiter; count never goes outside 0..DEPTH.

Reset
REQ-037 While rst low: state=ARB, last_grant=2*CHANNELS-1, all pointers, counts, flags, pop_data, push_done, pop_done = 0; mem_we=mem_re=0; mem_addr, mem_wdata = 0.
REQ-038 Reset mid-operation aborts the in-flight op with no done pulse; first ARB after release serves index 0 first.

Verification
REQ-039 Ch0 push 16'hA5A5 from reset -> mem_we with mem_addr=16'h0000 two cycles... i.e. ACCESS cycle; push_done 2 cycles after ARB; count[0]=1, empty[0]=0.
REQ-040 Ch2 push 128 words 0..127 then pop 128 -> addresses 16'h0100..16'h017F, data returned in order, full[2] at 128, empty[2] after, wptr/rptr wrapped to 0.
REQ-041 Push to full ch1 then one more push -> push_done pulses, no mem_we, overflow[1]=1, count[1]=128; pop on empty ch3 -> pop_done, underflow[3]=1.
REQ-042 All 8 requestors held high -> grants in order 0,1,...,7,0; no requestor waits more than 8 grants.
REQ-043 clear[0] during ch0 push ACCESS with count=5 -> push_done pulses, count[0]=0, flags 0; ch1 state unchanged.
REQ-044 rst low during pop WAIT -> no pop_done, all outputs 0; after release, pop on empty channel sets underflow only.
